// File: rtl/airlock_pkg.sv
// airlock_pkg: shared state and level-step direction types for the airlock sequencer
package airlock_pkg;
   typedef enum logic [1:0] {IDLE, DRAIN, FILL, FAULT} airlock_state_t;
   typedef enum logic [1:0] {DIR_HOLD, DIR_DOWN, DIR_UP} airlock_dir_t;
endpackage

// File: rtl/airlock_tick_gen.sv
// airlock_tick_gen: TICK_DIV prescaler, counts while enabled and fires step on its last count
module airlock_tick_gen #(
   parameter int TICK_DIV = 50000
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic step
);
   localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   logic [CW-1:0] cnt;
   assign step = enable && (cnt == CW'(TICK_DIV - 1));
   always_ff @(posedge clk)
      if (reset || clear) cnt <= '0;
      else if (enable) cnt <= step ? '0 : cnt + CW'(1);
endmodule

// File: rtl/airlock_drain_ctrl.sv
// airlock_drain_ctrl: chamber drain/fill sequencer stepping a level counter with door interlocks
// INTERLOCK_ABORT_EN: when defined, a door opening mid-operation faults instead of pausing
module airlock_drain_ctrl
   import airlock_pkg::*;
#(
   parameter int LEVEL_W     = 8,
   parameter int LEVEL_MAX   = 200,
   parameter int RESET_LEVEL = LEVEL_MAX,
   parameter int TICK_DIV    = 50000
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               drain_req,
   input  logic               fill_req,
   input  logic               stop_req,
   input  logic               clear_fault,
   input  logic               outer_door_closed,
   input  logic               inner_door_closed,
   output logic               draining,
   output logic               filling,
   output logic               empty,
   output logic               full,
   output logic               done,
   output logic               fault,
   output logic [LEVEL_W-1:0] level
);
`ifdef INTERLOCK_ABORT_EN
   localparam bit ABORT_EN = 1'b1;
`else
   localparam bit ABORT_EN = 1'b0;
`endif
   airlock_state_t state, state_nxt;
   airlock_dir_t dir;
   logic [LEVEL_W-1:0] level_nxt;
   logic done_nxt, sealed, active, step, last;
   assign sealed   = outer_door_closed && inner_door_closed;
   assign active   = (state == DRAIN) || (state == FILL);
   assign dir      = (state == DRAIN) ? DIR_DOWN : (state == FILL) ? DIR_UP : DIR_HOLD;
   assign last     = (dir == DIR_DOWN) ? (level == LEVEL_W'(1)) : (level == LEVEL_W'(LEVEL_MAX - 1));
   assign draining = state == DRAIN;
   assign filling  = state == FILL;
   assign fault    = state == FAULT;
   assign empty    = level == '0;
   assign full     = level == LEVEL_W'(LEVEL_MAX);
   // Holding the prescaler clear outside DRAIN/FILL guarantees it starts from 0 on entry
   airlock_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
      .clk    (clk),
      .reset  (reset),
      .clear  (!active),
      .enable (active && sealed),
      .step   (step)
   );
   always_comb begin
      state_nxt = state;
      level_nxt = level;
      done_nxt  = 1'b0;
      case (state)
         IDLE:
            if (drain_req && sealed && !empty) state_nxt = DRAIN;
            else if (fill_req && sealed && !full) state_nxt = FILL;
         DRAIN, FILL:
            if (stop_req) state_nxt = IDLE;
            else if (!sealed) state_nxt = ABORT_EN ? FAULT : state;
            else if (step) begin
               level_nxt = (dir == DIR_DOWN) ? level - LEVEL_W'(1) : level + LEVEL_W'(1);
               state_nxt = last ? IDLE : state;
               done_nxt  = last;
            end
         FAULT:
            if (clear_fault && sealed) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end
   always_ff @(posedge clk)
      if (reset) begin
         state <= IDLE;
         level <= LEVEL_W'(RESET_LEVEL);
         done  <= 1'b0;
      end else begin
         state <= state_nxt;
         level <= level_nxt;
         done  <= done_nxt;
      end
endmodule

// File: tb/tb_airlock_drain_ctrl.sv
// tb_airlock_drain_ctrl: scoreboard bench, reference model predicts outputs after every clock edge
module tb_airlock_drain_ctrl;
   localparam int LW = 8, LMAX = 5, RL = 5, TD = 4;
`ifdef INTERLOCK_ABORT_EN
   localparam bit ABORT = 1'b1;
`else
   localparam bit ABORT = 1'b0;
`endif
   logic clk = 1'b0, reset = 1'b1;
   logic drain_req = 0, fill_req = 0, stop_req = 0, clear_fault = 0;
   logic outer_door_closed = 1, inner_door_closed = 1;
   logic draining, filling, empty, full, done, fault;
   logic [LW-1:0] level;
   int checks = 0, errors = 0;
   int m_mode = 0, m_lvl = RL, m_rem = TD;
   bit m_done = 0;
   logic [LW+5:0] exp_q[$];

   airlock_drain_ctrl #(.LEVEL_W(LW), .LEVEL_MAX(LMAX), .RESET_LEVEL(RL), .TICK_DIV(TD)) dut (
      .clk(clk), .reset(reset), .drain_req(drain_req), .fill_req(fill_req), .stop_req(stop_req),
      .clear_fault(clear_fault), .outer_door_closed(outer_door_closed),
      .inner_door_closed(inner_door_closed), .draining(draining), .filling(filling), .empty(empty),
      .full(full), .done(done), .fault(fault), .level(level));

   always #5 clk = ~clk;

   // mode: 0 idle, 1 drain, 2 fill, 3 fault; m_rem counts sealed cycles left until the next step
   task automatic model();
      bit sealed = outer_door_closed && inner_door_closed;
      m_done = 0;
      if (reset) begin
         m_mode = 0; m_lvl = RL; m_rem = TD;
      end else case (m_mode)
         0: if (drain_req && sealed && m_lvl > 0) begin m_mode = 1; m_rem = TD; end
            else if (fill_req && sealed && m_lvl < LMAX) begin m_mode = 2; m_rem = TD; end
         1, 2: if (stop_req) m_mode = 0;
            else if (!sealed) begin if (ABORT) m_mode = 3; end
            else begin
               m_rem--;
               if (m_rem == 0) begin
                  m_rem = TD;
                  m_lvl += (m_mode == 1) ? -1 : 1;
                  if (m_lvl == 0 || m_lvl == LMAX) begin m_mode = 0; m_done = 1; end
               end
            end
         default: if (clear_fault && sealed) m_mode = 0;
      endcase
      exp_q.push_back({LW'(m_lvl), m_mode == 1, m_mode == 2, m_mode == 3, m_done, m_lvl == 0, m_lvl == LMAX});
   endtask

   // v = {reset, drain, fill, stop, clear_fault, outer, inner}
   task automatic tick(input logic [6:0] v);
      {reset, drain_req, fill_req, stop_req, clear_fault, outer_door_closed, inner_door_closed} = v;
      @(posedge clk);
      model();
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      repeat (n) tick(7'b0000011);
   endtask

   task automatic wait_lvl(input int l);
      for (int k = 0; k < 60 && m_lvl != l; k++) tick(7'b0000011);
   endtask

   initial begin : monitor
      logic [LW+5:0] e, a;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {level, draining, filling, fault, done, empty, full};
            checks++;
            if (a !== e) begin
               errors++;
               $display("FAIL outputs t=%0t level=%0d/%0d dr,fi,fa,dn,em,fu=%b/%b", $time,
                        a[LW+5:6], e[LW+5:6], a[5:0], e[5:0]);
            end
         end
      end
   end

   initial begin
      @(negedge clk);
      tick(7'b1000011); tick(7'b1000011);
      idle(2);
      tick(7'b0100011); wait_lvl(0); idle(3);
      tick(7'b1000011);
      tick(7'b0100001); tick(7'b0100010); idle(2);
      tick(7'b0100011); wait_lvl(3);
      repeat (6) tick(7'b0000001);
      tick(7'b0000111); idle(2);
      tick(7'b0100011); wait_lvl(0); idle(2);
      tick(7'b1000011); tick(7'b0100011); wait_lvl(2);
      tick(7'b0001011); idle(6);
      tick(7'b0010011); wait_lvl(5); idle(3);
      tick(7'b0100011); wait_lvl(3); idle(2);
      tick(7'b1000011); idle(2);
      tick(7'b0100011); wait_lvl(4); idle(1);
      tick(7'b0110011); idle(5);
      tick(7'b1000011); idle(3);
      for (int n = 0; n < 4000; n++) begin
         logic [6:0] v;
         v[6] = ($urandom_range(0, 499) == 0);
         v[5] = ($urandom_range(0, 19) == 0);
         v[4] = ($urandom_range(0, 19) == 0);
         v[3] = ($urandom_range(0, 59) == 0);
         v[2] = ($urandom_range(0, 9) == 0);
         v[1] = ($urandom_range(0, 24) != 0);
         v[0] = ($urandom_range(0, 24) != 0);
         tick(v);
      end
      {reset, drain_req, fill_req, stop_req, clear_fault} = '0;
      repeat (2) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain_queue left=%0d required=0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
